// File: rtl/lcd1602_row_driver_if.sv
// Pin bundle for a 1602 HD44780-compatible character LCD in 4-bit write-only mode.
interface lcd1602_row_driver_if;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [3:0] LCD_D;

    modport master (
        output LCD_E,
        output LCD_RS,
        output LCD_RW,
        output LCD_D
    );

    modport slave (
        input LCD_E,
        input LCD_RS,
        input LCD_RW,
        input LCD_D
    );
endinterface

// File: rtl/lcd1602_row_driver.sv
// Drives a 1602 character LCD from two 16-character rows: power-up wait,
// 4-bit init sequence, then an endless refresh of line 1 and line 2 taken
// from per-line snapshots of the row inputs.
module lcd1602_row_driver #(
    parameter int unsigned T_PWRUP = 1500000,
    parameter int unsigned T_SETUP = 5,
    parameter int unsigned T_EN    = 25,
    parameter int unsigned T_INIT  = 410000,
    parameter int unsigned T_CMD   = 4000,
    parameter int unsigned T_CLR   = 164000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [127:0]          row_A,
    input  logic [127:0]          row_B,
    lcd1602_row_driver_if.master  lcd,
    output logic                  ready
);

    typedef enum logic [2:0] {PWRUP, INIT_NIB, INIT_BYTE, LINE_ADDR, LINE_CHARS} state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_EN, PH_HOLD, PH_WAIT} phase_t;

    localparam logic [23:0] PWRUP_LAST = 24'(T_PWRUP - 1);
    localparam logic [23:0] SETUP_LAST = 24'(T_SETUP - 1);
    localparam logic [23:0] EN_LAST    = 24'(T_EN - 1);
    localparam logic [23:0] INIT_LAST  = 24'(T_INIT - 1);
    localparam logic [23:0] CMD_LAST   = 24'(T_CMD - 1);
    localparam logic [23:0] CLR_LAST   = 24'(T_CLR - 1);

    state_t         state_q, state_d;
    phase_t         phase_q, phase_d;
    logic [23:0]    timer_q, timer_d;
    logic           lo_q, lo_d;
    logic [1:0]     step_q, step_d;
    logic [3:0]     idx_q, idx_d;
    logic           line_q, line_d;
    logic [127:0]   shadow_q, shadow_d;
    logic           ready_q, ready_d;
    logic           e_q, e_d;
    logic           rs_q, rs_d;
    logic [3:0]     d_q, d_d;
    logic [23:0]    wait_last;
    logic [7:0]     byte_d;

    // State, timer, snapshot and registered pin outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= PWRUP;
            phase_q  <= PH_SETUP;
            timer_q  <= '0;
            lo_q     <= 1'b0;
            step_q   <= '0;
            idx_q    <= '0;
            line_q   <= 1'b0;
            shadow_q <= '0;
            ready_q  <= 1'b0;
            e_q      <= 1'b0;
            rs_q     <= 1'b0;
            d_q      <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            timer_q  <= timer_d;
            lo_q     <= lo_d;
            step_q   <= step_d;
            idx_q    <= idx_d;
            line_q   <= line_d;
            shadow_q <= shadow_d;
            ready_q  <= ready_d;
            e_q      <= e_d;
            rs_q     <= rs_d;
            d_q      <= d_d;
        end
    end

    // Sequencer: each nibble is SETUP/EN/HOLD; single init nibbles and the
    // second nibble of a byte are followed by the post-write WAIT.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        timer_d  = timer_q + 24'd1;
        lo_d     = lo_q;
        step_d   = step_q;
        idx_d    = idx_q;
        line_d   = line_q;
        shadow_d = shadow_q;
        ready_d  = ready_q;

        unique case (state_q)
            INIT_NIB:  wait_last = (step_q == 2'd0) ? INIT_LAST : CMD_LAST;
            INIT_BYTE: wait_last = (step_q == 2'd3) ? CLR_LAST : CMD_LAST;
            default:   wait_last = CMD_LAST;
        endcase

        if (state_q == LINE_ADDR && phase_q == PH_SETUP && !lo_q && timer_q == '0)
            shadow_d = line_q ? row_B : row_A;

        if (state_q == PWRUP) begin
            if (timer_q == PWRUP_LAST) begin
                state_d = INIT_NIB;
                phase_d = PH_SETUP;
                timer_d = '0;
                step_d  = '0;
                lo_d    = 1'b0;
            end
        end else begin
            unique case (phase_q)
                PH_SETUP: if (timer_q == SETUP_LAST) begin
                    phase_d = PH_EN;
                    timer_d = '0;
                end
                PH_EN: if (timer_q == EN_LAST) begin
                    phase_d = PH_HOLD;
                    timer_d = '0;
                end
                PH_HOLD: if (timer_q == SETUP_LAST) begin
                    timer_d = '0;
                    if (state_q != INIT_NIB && !lo_q) begin
                        lo_d    = 1'b1;
                        phase_d = PH_SETUP;
                    end else begin
                        phase_d = PH_WAIT;
                    end
                end
                default: if (timer_q == wait_last) begin
                    timer_d = '0;
                    phase_d = PH_SETUP;
                    lo_d    = 1'b0;
                    unique case (state_q)
                        INIT_NIB: begin
                            step_d = step_q + 2'd1;
                            if (step_q == 2'd3) state_d = INIT_BYTE;
                        end
                        INIT_BYTE: begin
                            step_d = step_q + 2'd1;
                            if (step_q == 2'd3) begin
                                state_d = LINE_ADDR;
                                line_d  = 1'b0;
                                ready_d = 1'b1;
                            end
                        end
                        LINE_ADDR: begin
                            state_d = LINE_CHARS;
                            idx_d   = '0;
                        end
                        default: begin
                            idx_d = idx_q + 4'd1;
                            if (idx_q == 4'd15) begin
                                state_d = LINE_ADDR;
                                line_d  = ~line_q;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    // Pin values decoded from the next sequencer state so E/RS/D leave flops;
    // outside a pulse this decode naturally repeats the last nibble.
    always_comb begin
        byte_d = 8'h00;
        rs_d   = 1'b0;
        d_d    = 4'h0;
        unique case (state_d)
            INIT_NIB: d_d = (step_d == 2'd3) ? 4'h2 : 4'h3;
            INIT_BYTE: begin
                unique case (step_d)
                    2'd0:    byte_d = 8'h28;
                    2'd1:    byte_d = 8'h0C;
                    2'd2:    byte_d = 8'h06;
                    default: byte_d = 8'h01;
                endcase
                d_d = lo_d ? byte_d[3:0] : byte_d[7:4];
            end
            LINE_ADDR: begin
                byte_d = line_d ? 8'hC0 : 8'h80;
                d_d    = lo_d ? byte_d[3:0] : byte_d[7:4];
            end
            LINE_CHARS: begin
                byte_d = shadow_d[{~idx_d, 3'b000} +: 8];
                rs_d   = 1'b1;
                d_d    = lo_d ? byte_d[3:0] : byte_d[7:4];
            end
            default: d_d = 4'h0;
        endcase
        e_d = (state_d != PWRUP) && (phase_d == PH_EN);
    end

    assign lcd.LCD_E  = e_q;
    assign lcd.LCD_RS = rs_q;
    assign lcd.LCD_RW = 1'b0;
    assign lcd.LCD_D  = d_q;
    assign ready      = ready_q;

endmodule

// File: tb/tb_lcd1602_row_driver.sv
// Scoreboard bench for lcd1602_row_driver with shortened timing parameters.
module tb_lcd1602_row_driver;
    localparam int TP  = 20;
    localparam int TS  = 1;
    localparam int TE  = 2;
    localparam int TI  = 8;
    localparam int TC  = 5;
    localparam int TCL = 10;
    localparam int NIB = 2*TS + TE;
    localparam int FIRST_RISE = TP + TS;
    localparam int READY_CYC  = TP + 4*NIB + TI + 3*TC + 8*NIB + 3*TC + TCL;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] row_A = '0;
    logic [127:0] row_B = '0;
    logic         ready;

    lcd1602_row_driver_if lcd_bus();

    lcd1602_row_driver #(
        .T_PWRUP(TP), .T_SETUP(TS), .T_EN(TE),
        .T_INIT(TI), .T_CMD(TC), .T_CLR(TCL)
    ) dut (
        .clk(clk), .reset(reset), .row_A(row_A), .row_B(row_B),
        .lcd(lcd_bus), .ready(ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [4:0] sb[$];
    bit sb_active = 1'b0;

    // Cycle index: 0 in the cycle after the last reset edge.
    int cyc = 0;
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push_nib(input logic rs, input logic [3:0] d);
        sb.push_back({rs, d});
    endtask

    task automatic push_byte(input logic rs, input logic [7:0] b);
        push_nib(rs, b[7:4]);
        push_nib(rs, b[3:0]);
    endtask

    task automatic push_line(input logic [7:0] addr, input logic [127:0] r);
        push_byte(1'b0, addr);
        for (int i = 0; i < 16; i++) push_byte(1'b1, r[127-8*i -: 8]);
    endtask

    // Strobe monitor: pulse width, RS/D stability, scoreboard compare.
    bit         e_prev = 1'b0, rdy_prev = 1'b0;
    int         rise_c = 0, strobe_cnt = 0, rises_since_rst = 0, first_rise = -1;
    int         rdy_rises = 0, rdy_cyc = -1;
    int         rise_log[$], fall_log[$];
    logic       rs_cap = 1'b0;
    logic [3:0] d_cap = '0;
    logic [4:0] exp_nib;
    always @(negedge clk) begin
        chk("rw_low", int'(lcd_bus.LCD_RW), 0);
        if (cyc == 0) begin
            e_prev = lcd_bus.LCD_E;
            rises_since_rst = 0;
            first_rise = -1;
        end else begin
            if (lcd_bus.LCD_E && !e_prev) begin
                rise_c = cyc;
                rs_cap = lcd_bus.LCD_RS;
                d_cap  = lcd_bus.LCD_D;
                rise_log.push_back(cyc);
                if (rises_since_rst == 0) first_rise = cyc;
                rises_since_rst++;
            end else if (lcd_bus.LCD_E && e_prev) begin
                chk("rsd_stable", int'({lcd_bus.LCD_RS, lcd_bus.LCD_D}), int'({rs_cap, d_cap}));
            end else if (!lcd_bus.LCD_E && e_prev) begin
                fall_log.push_back(cyc);
                strobe_cnt++;
                chk("e_width", cyc - rise_c, TE);
                if (sb.size() > 0) begin
                    exp_nib = sb.pop_front();
                    chk("strobe_rs_d", int'({rs_cap, d_cap}), int'(exp_nib));
                end else if (sb_active) begin
                    errors++;
                    $error("FAIL unexpected_strobe got %0h want none", {rs_cap, d_cap});
                end
            end
            e_prev = lcd_bus.LCD_E;
        end
        if (ready && !rdy_prev) begin
            rdy_rises++;
            rdy_cyc = cyc;
        end
        rdy_prev = ready;
    end

    task automatic wait_strobes(input int n, input int budget);
        int k = 0;
        while (strobe_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("strobe_count", strobe_cnt >= n ? n : strobe_cnt, n);
    endtask

    initial begin
        int k;
        row_A = "Prime #01 is 002";
        row_B = "Prime #02 is 003";
        sb_active = 1'b1;
        push_nib(1'b0, 4'h3); push_nib(1'b0, 4'h3);
        push_nib(1'b0, 4'h3); push_nib(1'b0, 4'h2);
        push_byte(1'b0, 8'h28); push_byte(1'b0, 8'h0C);
        push_byte(1'b0, 8'h06); push_byte(1'b0, 8'h01);
        push_line(8'h80, "Prime #01 is 002");
        push_line(8'hC0, "Prime #02 is 003");
        push_line(8'h80, "Prime #03 is 005");
        push_line(8'hC0, "Prime #02 is 003");

        repeat (3) @(negedge clk);
        chk("rst_e",     int'(lcd_bus.LCD_E), 0);
        chk("rst_rs",    int'(lcd_bus.LCD_RS), 0);
        chk("rst_d",     int'(lcd_bus.LCD_D), 0);
        chk("rst_ready", int'(ready), 0);
        reset = 1'b0;

        // Power-up and the four single init nibbles.
        wait_strobes(4, 300);
        chk("first_rise", first_rise, FIRST_RISE);
        chk("init_gap0", rise_log[1] - fall_log[0], TS + TI + TS);

        // Init bytes, clear wait and ready.
        wait_strobes(13, 400);
        chk("clr_gap", rise_log[12] - fall_log[11], TS + TCL + TS);
        chk("ready_cyc", rdy_cyc, READY_CYC);
        chk("ready_rises", rdy_rises, 1);

        // Change row_A after the third character of the first line-1 pass.
        wait_strobes(20, 400);
        row_A = "Prime #03 is 005";
        wait_strobes(148, 4000);
        chk("sb_drained", sb.size(), 0);
        chk("ready_once", rdy_rises, 1);

        // Reset while E is high during a character strobe.
        sb_active = 1'b0;
        wait_strobes(150, 400);
        k = 0;
        while (!lcd_bus.LCD_E && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("e_high_seen", int'(lcd_bus.LCD_E), 1);
        chk("in_chars_rs", int'(lcd_bus.LCD_RS), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_e",     int'(lcd_bus.LCD_E), 0);
        chk("mid_rst_rs",    int'(lcd_bus.LCD_RS), 0);
        chk("mid_rst_d",     int'(lcd_bus.LCD_D), 0);
        chk("mid_rst_ready", int'(ready), 0);
        push_nib(1'b0, 4'h3); push_nib(1'b0, 4'h3);
        push_nib(1'b0, 4'h3); push_nib(1'b0, 4'h2);
        sb_active = 1'b1;
        reset = 1'b0;
        wait_strobes(strobe_cnt + 4, 300);
        chk("first_rise_again", first_rise, FIRST_RISE);
        chk("sb_drained2", sb.size(), 0);
        sb_active = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
